// File: rtl/huffman_canon_encoder.sv
// huffman_canon_encoder
// Block-based canonical Huffman encoder. The block collects BLOCK_LEN
// symbols and counts how often each symbol occurs. It then builds a Huffman
// tree by repeatedly merging the two lightest nodes, derives each symbol's
// code length from its depth in the tree, and assigns canonical codes. The
// finished table is streamed out one entry per symbol, in symbol order.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high; aborts any block in progress
//   data_in          input symbol
//   data_enable      data_in valid; counted only while collecting
//   data_out_symbol  table entry symbol
//   data_out_length  code length, 0 = symbol absent from the block
//   data_out_code    canonical code, right-aligned, MSB sent first
//   data_out_valid   table entry valid
//   data_out_ready   downstream accepts the entry
//   data_out_state   1 = busy (not collecting); data_enable is ignored
//
// State    | meaning
// ---------+-----------------------------------------------------------
// COLLECT  | count incoming symbols until BLOCK_LEN have been taken
// SCAN     | walk all nodes once, tracking the two lightest active nodes
// MERGE    | create an internal node from the pair found by SCAN
// LENGTH   | per leaf, count parent hops up to the root
// CANON    | assign canonical codes, shortest length first
// OUTPUT   | stream one table entry per symbol with valid/ready
module huffman_canon_encoder #(
  parameter int SYM_W     = 3,
  parameter int BLOCK_LEN = 20,
  parameter int MAX_LEN   = 15,
  parameter int CNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SYM_W-1:0]   data_in,
  input  logic               data_enable,
  output logic [SYM_W-1:0]   data_out_symbol,
  output logic [3:0]         data_out_length,
  output logic [MAX_LEN-1:0] data_out_code,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               data_out_state
);

  localparam int NUM_SYM = 1 << SYM_W;
  localparam int NODES   = 2 * NUM_SYM - 1;
  localparam int IW      = SYM_W + 1;

  localparam logic [SYM_W-1:0] LAST_SYM  = SYM_W'(NUM_SYM - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BLOCK_LEN - 1);
  localparam logic [IW-1:0]    FIRST_INT = IW'(NUM_SYM);
  localparam logic [3:0]       LAST_LEN  = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_SCAN,
    S_MERGE,
    S_LENGTH,
    S_CANON,
    S_OUTPUT
  } state_e;

  state_e state_q, state_d;

  // Node storage: indices below NUM_SYM are leaves (weight = frequency),
  // the rest are internal nodes created by merges.
  logic [CNT_W-1:0]   w_q       [NODES];
  logic [IW-1:0]      par_q     [NODES];
  logic               has_par_q [NODES];
  logic [3:0]         len_q     [NUM_SYM];
  logic [MAX_LEN-1:0] code_q    [NUM_SYM];

  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [IW-1:0]      node_cnt_q, node_cnt_d;
  logic [IW-1:0]      scan_idx_q, scan_idx_d;
  logic [IW-1:0]      min1_q, min1_d;
  logic [IW-1:0]      min2_q, min2_d;
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [IW-1:0]      cur_q, cur_d;
  logic [3:0]         hops_q, hops_d;
  logic [3:0]         cl_q, cl_d;
  logic [MAX_LEN-1:0] next_code_q, next_code_d;

  logic               inc_en;
  logic               merge_en;
  logic               len_wr;
  logic [3:0]         len_val;
  logic               code_wr;
  logic               clr_all;

  // Running two-minimum update with the node under the scan cursor folded
  // in. Strict less-than keeps the earlier (lower index) node on ties, and
  // the first minimum found becomes the left child.
  logic               cand_act;
  logic [IW-1:0]      m1_n, m2_n;
  logic               v1_n, v2_n;

  always_comb begin
    cand_act = (w_q[scan_idx_q] != '0) && !has_par_q[scan_idx_q];
    m1_n = min1_q;
    m2_n = min2_q;
    v1_n = v1_q;
    v2_n = v2_q;
    if (cand_act) begin
      if (!v1_q || (w_q[scan_idx_q] < w_q[min1_q])) begin
        m2_n = min1_q;
        v2_n = v1_q;
        m1_n = scan_idx_q;
        v1_n = 1'b1;
      end else if (!v2_q || (w_q[scan_idx_q] < w_q[min2_q])) begin
        m2_n = scan_idx_q;
        v2_n = 1'b1;
      end
    end
  end

  logic [MAX_LEN-1:0] code_inc;

  always_comb begin
    state_d     = state_q;
    blk_cnt_d   = blk_cnt_q;
    node_cnt_d  = node_cnt_q;
    scan_idx_d  = scan_idx_q;
    min1_d      = min1_q;
    min2_d      = min2_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    sym_d       = sym_q;
    cur_d       = cur_q;
    hops_d      = hops_q;
    cl_d        = cl_q;
    next_code_d = next_code_q;
    inc_en      = 1'b0;
    merge_en    = 1'b0;
    len_wr      = 1'b0;
    len_val     = '0;
    code_wr     = 1'b0;
    clr_all     = 1'b0;
    code_inc    = next_code_q;

    case (state_q)
      S_COLLECT: begin
        if (data_enable) begin
          inc_en    = 1'b1;
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
          if (blk_cnt_q == LAST_CNT) begin
            state_d    = S_SCAN;
            node_cnt_d = FIRST_INT;
            scan_idx_d = '0;
            v1_d       = 1'b0;
            v2_d       = 1'b0;
          end
        end
      end

      S_SCAN: begin
        min1_d = m1_n;
        min2_d = m2_n;
        v1_d   = v1_n;
        v2_d   = v2_n;
        if (scan_idx_q == node_cnt_q - IW'(1)) begin
          // Fewer than two active nodes left means the tree is complete
          // (or the block held a single distinct symbol).
          if (v2_n) begin
            state_d = S_MERGE;
          end else begin
            state_d = S_LENGTH;
            sym_d   = '0;
            cur_d   = '0;
            hops_d  = '0;
          end
        end else begin
          scan_idx_d = scan_idx_q + IW'(1);
        end
      end

      S_MERGE: begin
        merge_en   = 1'b1;
        node_cnt_d = node_cnt_q + IW'(1);
        scan_idx_d = '0;
        v1_d       = 1'b0;
        v2_d       = 1'b0;
        state_d    = S_SCAN;
      end

      S_LENGTH: begin
        if (has_par_q[cur_q]) begin
          cur_d  = par_q[cur_q];
          hops_d = hops_q + 4'd1;
        end else begin
          len_wr = 1'b1;
          // A present leaf with no parent is the lone symbol of the block.
          if (w_q[IW'(sym_q)] == '0) begin
            len_val = '0;
          end else if (hops_q == '0) begin
            len_val = 4'd1;
          end else begin
            len_val = hops_q;
          end
          hops_d = '0;
          if (sym_q == LAST_SYM) begin
            state_d     = S_CANON;
            sym_d       = '0;
            cl_d        = 4'd1;
            next_code_d = '0;
          end else begin
            sym_d = sym_q + SYM_W'(1);
            cur_d = IW'(sym_q) + IW'(1);
          end
        end
      end

      S_CANON: begin
        if (len_q[sym_q] == cl_q) begin
          code_wr  = 1'b1;
          code_inc = next_code_q + MAX_LEN'(1);
        end
        if (sym_q == LAST_SYM) begin
          next_code_d = code_inc << 1;
          sym_d       = '0;
          if (cl_q == LAST_LEN) begin
            state_d = S_OUTPUT;
          end else begin
            cl_d = cl_q + 4'd1;
          end
        end else begin
          next_code_d = code_inc;
          sym_d       = sym_q + SYM_W'(1);
        end
      end

      S_OUTPUT: begin
        if (data_out_ready) begin
          if (sym_q == LAST_SYM) begin
            clr_all   = 1'b1;
            blk_cnt_d = '0;
            sym_d     = '0;
            state_d   = S_COLLECT;
          end else begin
            sym_d = sym_q + SYM_W'(1);
          end
        end
      end

      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_COLLECT;
      blk_cnt_q   <= '0;
      node_cnt_q  <= FIRST_INT;
      scan_idx_q  <= '0;
      min1_q      <= '0;
      min2_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      sym_q       <= '0;
      cur_q       <= '0;
      hops_q      <= '0;
      cl_q        <= 4'd1;
      next_code_q <= '0;
    end else begin
      state_q     <= state_d;
      blk_cnt_q   <= blk_cnt_d;
      node_cnt_q  <= node_cnt_d;
      scan_idx_q  <= scan_idx_d;
      min1_q      <= min1_d;
      min2_q      <= min2_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      sym_q       <= sym_d;
      cur_q       <= cur_d;
      hops_q      <= hops_d;
      cl_q        <= cl_d;
      next_code_q <= next_code_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clr_all) begin
      for (int i = 0; i < NODES; i++) begin
        w_q[i]       <= '0;
        par_q[i]     <= '0;
        has_par_q[i] <= 1'b0;
      end
      for (int s = 0; s < NUM_SYM; s++) begin
        len_q[s]  <= '0;
        code_q[s] <= '0;
      end
    end else begin
      if (inc_en) begin
        w_q[IW'(data_in)] <= w_q[IW'(data_in)] + CNT_W'(1);
      end
      if (merge_en) begin
        w_q[node_cnt_q]   <= w_q[min1_q] + w_q[min2_q];
        par_q[min1_q]     <= node_cnt_q;
        par_q[min2_q]     <= node_cnt_q;
        has_par_q[min1_q] <= 1'b1;
        has_par_q[min2_q] <= 1'b1;
      end
      if (len_wr) begin
        len_q[sym_q] <= len_val;
      end
      if (code_wr) begin
        code_q[sym_q] <= next_code_q;
      end
    end
  end

  // Outputs are driven straight from registers, so they hold steady under
  // backpressure; outside OUTPUT they read as zero.
  always_comb begin
    data_out_valid  = (state_q == S_OUTPUT);
    data_out_state  = (state_q != S_COLLECT);
    data_out_symbol = '0;
    data_out_length = '0;
    data_out_code   = '0;
    if (state_q == S_OUTPUT) begin
      data_out_symbol = sym_q;
      data_out_length = len_q[sym_q];
      if (len_q[sym_q] != '0) begin
        data_out_code = code_q[sym_q];
      end
    end
  end

endmodule

// File: tb/tb_huffman_canon_encoder.sv
module tb_huffman_canon_encoder;

  localparam int SYM_W     = 3;
  localparam int NUM_SYM   = 8;
  localparam int BLOCK_LEN = 20;
  localparam int MAX_LEN   = 15;
  localparam int CNT_W     = 8;
  localparam int LAT_MAX   = (NUM_SYM-1)*(2*NUM_SYM) + NUM_SYM*MAX_LEN + MAX_LEN*NUM_SYM + 8;

  logic               clock = 1'b0;
  logic               reset;
  logic [SYM_W-1:0]   data_in;
  logic               data_enable;
  logic [SYM_W-1:0]   data_out_symbol;
  logic [3:0]         data_out_length;
  logic [MAX_LEN-1:0] data_out_code;
  logic               data_out_valid;
  logic               data_out_ready;
  logic               data_out_state;

  int n_pass  = 0;
  int n_total = 0;
  int blk_q[$];

  huffman_canon_encoder #(
    .SYM_W(SYM_W), .BLOCK_LEN(BLOCK_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_enable(data_enable),
    .data_out_symbol(data_out_symbol), .data_out_length(data_out_length),
    .data_out_code(data_out_code), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_state(data_out_state)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: textbook Huffman on (weight, index) order, then canonical codes.
  task automatic ref_model(input int cnt[NUM_SYM], output int len[NUM_SYM], output int code[NUM_SYM]);
    int w[2*NUM_SYM-1];
    int par[2*NUM_SYM-1];
    int n, a, b, d, node, c;
    for (int i = 0; i < 2*NUM_SYM-1; i++) begin
      w[i]   = (i < NUM_SYM) ? cnt[i] : 0;
      par[i] = -1;
    end
    n = NUM_SYM;
    for (int m = 0; m < NUM_SYM; m++) begin
      a = -1;
      for (int i = 0; i < n; i++)
        if (w[i] > 0 && par[i] < 0 && (a < 0 || w[i] < w[a])) a = i;
      b = -1;
      for (int i = 0; i < n; i++)
        if (i != a && w[i] > 0 && par[i] < 0 && (b < 0 || w[i] < w[b])) b = i;
      if (b < 0) break;
      w[n] = w[a] + w[b];
      par[a] = n;
      par[b] = n;
      n++;
    end
    for (int s = 0; s < NUM_SYM; s++) begin
      code[s] = 0;
      if (cnt[s] == 0) len[s] = 0;
      else begin
        d = 0;
        node = s;
        while (par[node] >= 0) begin
          node = par[node];
          d++;
        end
        len[s] = (d == 0) ? 1 : d;
      end
    end
    c = 0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      for (int s = 0; s < NUM_SYM; s++)
        if (len[s] == l) begin
          code[s] = c;
          c++;
        end
      c = c << 1;
    end
  endtask

  task automatic fill_block(input int cnt[NUM_SYM]);
    int j, t;
    blk_q.delete();
    for (int s = 0; s < NUM_SYM; s++)
      for (int k = 0; k < cnt[s]; k++) blk_q.push_back(s);
    for (int i = blk_q.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = blk_q[i];
      blk_q[i] = blk_q[j];
      blk_q[j] = t;
    end
  endtask

  task automatic random_counts(output int cnt[NUM_SYM]);
    int s;
    for (int i = 0; i < NUM_SYM; i++) cnt[i] = 0;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      s = int'($urandom_range(0, NUM_SYM-1));
      if ($urandom_range(0, 1) == 1) s = s & 3;
      cnt[s]++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the last symbol was taken.
  task automatic apply_block(input string name);
    n_total++;
    if (data_out_state !== 1'b0) $display("FAIL %s idle_before_block: got state %0b want 0", name, data_out_state);
    else n_pass++;
    foreach (blk_q[i]) begin
      data_in = SYM_W'(blk_q[i]);
      data_enable = 1'b1;
      @(negedge clock);
    end
    data_enable = 1'b0;
    n_total++;
    if (data_out_state !== 1'b1) $display("FAIL %s busy_after_block: got state %0b want 1", name, data_out_state);
    else n_pass++;
  endtask

  // mode 0: ready=1, mode 1: ready 1,0,0 repeating, mode 2: random ready.
  task automatic run_table(input int exp_len[NUM_SYM], input int exp_code[NUM_SYM],
                           input int mode, input bit junk, input string name);
    int idx = 0, cyc = 0, first_lat = -1, ready_k = 0;
    bit stalled = 1'b0;
    logic [SYM_W-1:0]   h_sym  = '0;
    logic [3:0]         h_len  = '0;
    logic [MAX_LEN-1:0] h_code = '0;
    while (idx < NUM_SYM && cyc < 4000) begin
      if (junk) begin
        data_enable = 1'($urandom_range(0, 1));
        data_in = SYM_W'($urandom);
      end
      if (stalled) begin
        n_total++;
        if (data_out_valid !== 1'b1 || data_out_symbol !== h_sym || data_out_length !== h_len || data_out_code !== h_code)
          $display("FAIL %s hold: got v%0b s%0d l%0d c%0h want v1 s%0d l%0d c%0h", name, data_out_valid,
                   data_out_symbol, data_out_length, data_out_code, h_sym, h_len, h_code);
        else n_pass++;
      end
      if (data_out_valid === 1'b1) begin
        if (first_lat < 0) begin
          first_lat = cyc;
          n_total++;
          if (first_lat > LAT_MAX) $display("FAIL %s latency: got %0d want <= %0d", name, first_lat, LAT_MAX);
          else n_pass++;
        end
        case (mode)
          0: data_out_ready = 1'b1;
          1: data_out_ready = (ready_k % 3 == 0);
          default: data_out_ready = 1'($urandom_range(0, 1));
        endcase
        ready_k++;
        if (data_out_ready) begin
          n_total++;
          if (data_out_symbol !== SYM_W'(idx) || data_out_length !== 4'(exp_len[idx]) || data_out_code !== MAX_LEN'(exp_code[idx]))
            $display("FAIL %s entry%0d: got s%0d l%0d c%0h want s%0d l%0d c%0h", name, idx, data_out_symbol,
                     data_out_length, data_out_code, idx, exp_len[idx], exp_code[idx]);
          else n_pass++;
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          h_sym = data_out_symbol;
          h_len = data_out_length;
          h_code = data_out_code;
        end
      end else begin
        data_out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      cyc++;
      if (idx < NUM_SYM) @(negedge clock);
    end
    data_enable = 1'b0;
    if (idx < NUM_SYM) begin
      n_total++;
      $display("FAIL %s timeout: got %0d entries want %0d", name, idx, NUM_SYM);
    end
    @(negedge clock);
    n_total++;
    if (data_out_valid !== 1'b0 || data_out_state !== 1'b0)
      $display("FAIL %s done: got valid %0b state %0b want 0 0", name, data_out_valid, data_out_state);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string name);
    n_total++;
    if (data_out_valid !== 1'b0 || data_out_state !== 1'b0 || data_out_symbol !== '0 ||
        data_out_length !== '0 || data_out_code !== '0)
      $display("FAIL %s: got v%0b st%0b s%0d l%0d c%0h want all 0", name, data_out_valid, data_out_state,
               data_out_symbol, data_out_length, data_out_code);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_enable = 1'b0;
    data_in = '0;
    data_out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_symbol();
    int cnt[NUM_SYM] = '{0, 0, 0, 0, 0, 20, 0, 0};
    int el[NUM_SYM]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    int ec[NUM_SYM]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    fill_block(cnt);
    apply_block("single");
    run_table(el, ec, 0, 1'b0, "single");
  endtask

  task automatic test_skewed();
    int cnt[NUM_SYM] = '{10, 5, 3, 2, 0, 0, 0, 0};
    int el[NUM_SYM]  = '{1, 2, 3, 3, 0, 0, 0, 0};
    int ec[NUM_SYM]  = '{0, 2, 6, 7, 0, 0, 0, 0};
    fill_block(cnt);
    apply_block("skewed");
    run_table(el, ec, 0, 1'b0, "skewed");
  endtask

  task automatic test_equal();
    int cnt[NUM_SYM] = '{5, 5, 5, 5, 0, 0, 0, 0};
    int el[NUM_SYM]  = '{2, 2, 2, 2, 0, 0, 0, 0};
    int ec[NUM_SYM]  = '{0, 1, 2, 3, 0, 0, 0, 0};
    fill_block(cnt);
    apply_block("equal");
    run_table(el, ec, 0, 1'b0, "equal");
  endtask

  task automatic test_backpressure();
    int cnt[NUM_SYM] = '{5, 5, 5, 5, 0, 0, 0, 0};
    int el[NUM_SYM]  = '{2, 2, 2, 2, 0, 0, 0, 0};
    int ec[NUM_SYM]  = '{0, 1, 2, 3, 0, 0, 0, 0};
    fill_block(cnt);
    apply_block("backpressure");
    run_table(el, ec, 1, 1'b0, "backpressure");
  endtask

  task automatic test_back_to_back();
    int cnt[NUM_SYM];
    int el[NUM_SYM];
    int ec[NUM_SYM];
    random_counts(cnt);
    ref_model(cnt, el, ec);
    fill_block(cnt);
    apply_block("junk_first");
    run_table(el, ec, 2, 1'b1, "junk_first");
    random_counts(cnt);
    ref_model(cnt, el, ec);
    fill_block(cnt);
    apply_block("b2b_second");
    run_table(el, ec, 2, 1'b0, "b2b_second");
  endtask

  task automatic fresh_block_after_reset(input string name);
    int cnt[NUM_SYM];
    int el[NUM_SYM];
    int ec[NUM_SYM];
    random_counts(cnt);
    ref_model(cnt, el, ec);
    fill_block(cnt);
    apply_block(name);
    run_table(el, ec, 0, 1'b0, name);
  endtask

  task automatic test_reset_mid_build();
    int cnt[NUM_SYM] = '{3, 4, 2, 1, 6, 1, 2, 1};
    fill_block(cnt);
    apply_block("rst_build_pre");
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("rst_build_out");
    reset = 1'b0;
    fresh_block_after_reset("rst_build_fresh");
  endtask

  task automatic test_reset_mid_output();
    int cnt[NUM_SYM] = '{1, 1, 2, 2, 3, 3, 4, 4};
    int cyc = 0;
    fill_block(cnt);
    apply_block("rst_out_pre");
    data_out_ready = 1'b0;
    while (data_out_valid !== 1'b1 && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    n_total++;
    if (data_out_valid !== 1'b1) $display("FAIL rst_out_wait: got valid %0b want 1", data_out_valid);
    else n_pass++;
    data_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("rst_out_out");
    reset = 1'b0;
    fresh_block_after_reset("rst_out_fresh");
  endtask

  task automatic test_random();
    int cnt[NUM_SYM];
    int el[NUM_SYM];
    int ec[NUM_SYM];
    for (int r = 0; r < 6; r++) begin
      random_counts(cnt);
      ref_model(cnt, el, ec);
      fill_block(cnt);
      apply_block("random");
      run_table(el, ec, 2, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_symbol();
    test_skewed();
    test_equal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_build();
    test_reset_mid_output();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
